// File: rtl/mult_pkg.sv
// Shared definitions for the multiply-recompose datapath and its step counter.
package mult_pkg;

  localparam int N_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter width for N steps; a 1-step counter still needs one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mr_step_counter.sv
// Step counter with synchronous clear, enable and terminal-count flag at N-1.
module mr_step_counter
  import mult_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = cnt_w(N);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CW'(N - 1));

endmodule

// File: rtl/mult_recompose.sv
// Sequential shift-add multiply-accumulate, P = portA*portB + portR, init/done handshake.
module mult_recompose
  import mult_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           init,
  input  logic [N-1:0]   portA,
  input  logic [N-1:0]   portB,
  input  logic [N-1:0]   portR,
  output logic [2*N-1:0] P,
  output logic           busy,
  output logic           done
);

  state_e           state_q, state_d;
  logic [N-1:0]     a_sh_q, a_sh_d;
  logic [2*N-1:0]   b_sh_q, b_sh_d;
  logic [2*N-1:0]   acc_q, acc_d;
  logic [2*N-1:0]   p_q, p_d;
  logic             done_q, done_d;
  logic             cnt_clr, cnt_en, cnt_tc;

  mr_step_counter #(.N(N)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    p_d     = p_q;
    done_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (init) begin
          a_sh_d  = portA;
          b_sh_d  = {{N{1'b0}}, portB};
          acc_d   = {{N{1'b0}}, portR};
          cnt_clr = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Result is bounded below 2^2N, so the 2N-bit add never carries out.
        if (a_sh_q[0]) begin
          acc_d = acc_q + b_sh_q;
        end
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q << 1;
        cnt_en = 1'b1;
        if (cnt_tc) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        p_d     = acc_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      done_q  <= done_d;
    end
  end

  assign P    = p_q;
  assign done = done_q;
  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mult_recompose.sv
// Self-checking bench for mult_recompose (N=3): vector table, corner sequences, round-trip, random.
module tb_mult_recompose;

  logic       clk = 1'b0;
  logic       rst;
  logic       init;
  logic [2:0] portA, portB, portR;
  logic [5:0] P;
  logic       busy, done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int a;
    int b;
    int r;
    int p;
  } vec_t;

  vec_t tbl[6];

  mult_recompose #(.N(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .init  (init),
    .portA (portA),
    .portB (portB),
    .portR (portR),
    .P     (P),
    .busy  (busy),
    .done  (done)
  );

  always #1 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One transaction: init pulse, optional ignored second init, wait for done with a bound.
  task automatic run_op(input int a, input int b, input int r, input int exp_p,
                        input string tag, input bit dbl);
    int  cyc;
    bit  seen;
    portA = 3'(a);
    portB = 3'(b);
    portR = 3'(r);
    init  = 1'b1;
    seen  = 1'b0;
    cyc   = -1;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (i == 1) begin
        init  = dbl;
        portA = 3'($urandom);
        portB = 3'($urandom);
        portR = 3'($urandom);
        chk({tag, " busy_in_run"}, 32'(busy), 1);
      end else if (i == 2) begin
        init = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        cyc  = i;
      end
    end
    init = 1'b0;
    chk({tag, " latency"}, 32'(cyc), 5);
    chk({tag, " P"}, 32'(P), 32'(exp_p));
    chk({tag, " busy_at_done"}, 32'(busy), 0);
    $display("op %s A=%0d B=%0d R=%0d P=%0d expect=%0d latency=%0d", tag, a, b, r, P, exp_p, cyc);
    @(negedge clk);
    chk({tag, " done_single"}, 32'(done), 0);
  endtask

  initial begin
    int  q, m, ra, rb, rr;
    bit  saw_done;

    tbl[0] = '{a: 3, b: 2, r: 1, p: 7};
    tbl[1] = '{a: 7, b: 7, r: 7, p: 56};
    tbl[2] = '{a: 5, b: 0, r: 3, p: 3};
    tbl[3] = '{a: 0, b: 6, r: 0, p: 0};
    tbl[4] = '{a: 1, b: 7, r: 0, p: 7};
    tbl[5] = '{a: 6, b: 5, r: 2, p: 32};

    rst   = 1'b1;
    init  = 1'b0;
    portA = '0;
    portB = '0;
    portR = '0;
    repeat (3) @(negedge clk);
    chk("reset P", 32'(P), 0);
    chk("reset done", 32'(done), 0);
    chk("reset busy", 32'(busy), 0);
    rst = 1'b0;

    run_op(3, 2, 1, 7, "first", 1'b0);

    // Second init one cycle after the first must be ignored.
    run_op(2, 3, 4, 10, "dbl_init", 1'b1);

    // Reset during RUN aborts with no done pulse and P back to zero.
    portA = 3'd7; portB = 3'd7; portR = 3'd7; init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst P", 32'(P), 0);
    chk("midrst busy", 32'(busy), 0);
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("midrst no_done", 32'(saw_done), 0);
    $display("op midrst P=%0d busy=%0d saw_done=%0d", P, busy, saw_done);
    run_op(4, 3, 2, 14, "after_rst", 1'b0);

    // init and rst together: reset wins, block stays idle.
    rst = 1'b1; init = 1'b1; portA = 3'd5; portB = 3'd5; portR = 3'd5;
    @(negedge clk);
    rst = 1'b0; init = 1'b0;
    chk("rst_init busy", 32'(busy), 0);
    chk("rst_init P", 32'(P), 0);
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    chk("rst_init idle", 32'(saw_done), 0);
    $display("op rst_init busy=%0d P=%0d", busy, P);

    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].p, $sformatf("tbl%0d", i), 1'b0);
    end

    // Divide round trip: quotient*divisor + remainder rebuilds the dividend.
    for (int a = 0; a < 8; a++) begin
      for (int b = 1; b < 8; b++) begin
        q = a / b;
        m = a % b;
        run_op(q, b, m, a, $sformatf("rt_%0d_%0d", a, b), 1'b0);
      end
    end

    for (int i = 0; i < 40; i++) begin
      ra = int'($urandom_range(7, 0));
      rb = int'($urandom_range(7, 0));
      rr = int'($urandom_range(7, 0));
      run_op(ra, rb, rr, ra * rb + rr, $sformatf("rnd%0d", i), i[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
